piso_shift_register: RTL

- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per enabled cycle, LSB first.
- Counterpart to the enable/clear flip-flop storage chain: that chain writes bits into storage, while this block reads a stored word back out serially.
- Sits between a word-wide producer and a single-wire serial consumer that can stall it through a shift-enable input.

---
 rtl/piso_shift_register.sv | 97 +++++++++
 1 files changed

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out transmitter.
// A WIDTH-bit word is accepted over a valid/ready handshake and then emitted
// LSB first, one bit per cycle in which the consumer raises io_shift_enable.
// On the final bit, a new word can be loaded in the same cycle, so words can
// stream back to back with no gap.
module piso_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,            // asynchronous, active-low
  input  logic             io_load_valid,
  output logic             io_load_ready,
  input  logic [WIDTH-1:0] io_load_data,
  input  logic             io_shift_enable,
  input  logic             io_clear,
  output logic             io_serial_out,
  output logic             io_serial_valid,
  output logic             io_last,
  output logic             io_busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic in_shift;
  logic last_bit;
  logic load_fire;

  // Output decode: everything follows from the current state and bit index.
  always_comb begin
    in_shift        = (state_q == SHIFT);
    last_bit        = in_shift && (cnt_q == LAST);
    io_serial_out   = in_shift & shreg_q[0];
    io_serial_valid = in_shift;
    io_busy         = in_shift;
    io_last         = last_bit;
    // Ready in IDLE, or when the final bit is being consumed right now;
    // a clear in progress blocks any load.
    io_load_ready   = !io_clear && (!in_shift || (last_bit && io_shift_enable));
    load_fire       = io_load_valid && io_load_ready;
  end

  // Next-state logic: clear beats load, load beats shift.
  always_comb begin
    // NOTE: every signal gets a hold default first so no branch can leave it
    // unassigned and infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    if (io_clear) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_fire) begin
      // Covers both a fresh load from IDLE and a back-to-back reload on
      // the final bit.
      state_d = SHIFT;
      shreg_d = io_load_data;
      cnt_d   = '0;
    end else if (in_shift && io_shift_enable) begin
      if (last_bit) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
